// File: rtl/pi_spi_bridge.sv
`default_nettype none
// ============================================================================
// pi_spi_bridge : SPI (mode 0) slave to PiBus single-cycle transaction bridge
// Revision      : 1.0 - initial release
// ============================================================================
package pi_spi_bridge_pkg;

  typedef struct packed {
    logic ce_prg;
    logic ce_chr;
    logic ce_srm;
    logic ce_cfg;
  } pi_map_t;

  typedef struct packed {
    logic        act;
    logic        we;
    logic [23:0] addr;
    logic [7:0]  dato;
    pi_map_t     map;
  } pi_bus_t;

endpackage

module pi_spi_bridge
  import pi_spi_bridge_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] pi_di,
  output pi_bus_t    pi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR2 = 3'd2;
  localparam logic [2:0] S_ADDR1 = 3'd3;
  localparam logic [2:0] S_ADDR0 = 3'd4;
  localparam logic [2:0] S_WDATA = 3'd5;
  localparam logic [2:0] S_RDATA = 3'd6;
  localparam logic [2:0] S_DROP  = 3'd7;

  localparam logic [1:0] M_WR   = 2'd0;
  localparam logic [1:0] M_RD   = 2'd1;
  localparam logic [1:0] M_DROP = 2'd2;

  localparam int            LW       = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT);

  // Input synchroniser and edge detector
  logic [1:0] sclk_sync_q;
  logic [1:0] ss_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sclk_prev_q;
  logic       rise_q;
  logic       fall_q;
  logic       mosi_q;
  logic       ss_s;

  // Session and bus state
  logic [2:0]    state_q,   state_d;
  logic [1:0]    mode_q,    mode_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_q,      rx_d;
  logic          act_q,     act_d;
  logic          we_q,      we_d;
  logic [23:0]   addr_q,    addr_d;
  logic [7:0]    dato_q,    dato_d;
  logic [7:0]    txbuf_q,   txbuf_d;
  logic [7:0]    tx_sr_q,   tx_sr_d;
  logic          miso_q,    miso_d;
  logic          rd_pend_q, rd_pend_d;
  logic [LW-1:0] lat_q,     lat_d;
  logic [7:0]    rx_byte;
  pi_map_t       map;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      ss_sync_q   <= {ss_sync_q[0], spi_ss};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[1];
      rise_q      <= sclk_sync_q[1] & ~sclk_prev_q;
      fall_q      <= ~sclk_sync_q[1] & sclk_prev_q;
      // MOSI registered alongside the edge flag so both refer to the same pin instant
      mosi_q      <= mosi_sync_q[1];
    end
  end

  assign ss_s    = ss_sync_q[1];
  assign rx_byte = {rx_q, mosi_q};

  always_comb begin
    map.ce_prg = ~addr_q[23];
    map.ce_chr = (addr_q[23:21] == 3'b100);
    map.ce_srm = (addr_q[23:18] == 6'b101000);
    map.ce_cfg = (addr_q[23:4] == 20'hFFFF0);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    act_d     = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    dato_d    = dato_q;
    txbuf_d   = txbuf_q;
    tx_sr_d   = tx_sr_q;
    miso_d    = miso_q;
    rd_pend_d = rd_pend_q;
    lat_d     = lat_q;

    if (act_q && we_q) begin
      addr_d = addr_q + 24'd1;
    end

    if (ss_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      rd_pend_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      state_d   = S_CMD;
      bit_cnt_d = 3'd0;
    end else begin
      // Outstanding prefetch: capture the target byte, then step to the next address
      if (rd_pend_q) begin
        if (lat_q == '0) begin
          txbuf_d   = pi_di;
          addr_d    = addr_q + 24'd1;
          rd_pend_d = 1'b0;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end

      if (rise_q) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            S_CMD: begin
              if (rx_byte == 8'h01) begin
                mode_d = M_WR;
              end else if (rx_byte == 8'h00) begin
                mode_d = M_RD;
              end else begin
                mode_d = M_DROP;
              end
              state_d = S_ADDR2;
            end
            S_ADDR2: begin
              addr_d[23:16] = rx_byte;
              state_d       = S_ADDR1;
            end
            S_ADDR1: begin
              addr_d[15:8] = rx_byte;
              state_d      = S_ADDR0;
            end
            S_ADDR0: begin
              addr_d[7:0] = rx_byte;
              if (mode_q == M_WR) begin
                state_d = S_WDATA;
              end else if (mode_q == M_RD) begin
                state_d   = S_RDATA;
                act_d     = 1'b1;
                we_d      = 1'b0;
                rd_pend_d = 1'b1;
                lat_d     = LAT_INIT;
              end else begin
                state_d = S_DROP;
              end
            end
            S_WDATA: begin
              dato_d = rx_byte;
              we_d   = 1'b1;
              act_d  = 1'b1;
            end
            S_RDATA: begin
              act_d     = 1'b1;
              we_d      = 1'b0;
              rd_pend_d = 1'b1;
              lat_d     = LAT_INIT;
            end
            default: begin
            end
          endcase
        end
      end

      // First falling edge of a byte presents the prefetched byte; later ones shift
      if (fall_q) begin
        if (state_q == S_RDATA) begin
          if (bit_cnt_q == 3'd0) begin
            miso_d  = txbuf_q[7];
            tx_sr_d = {txbuf_q[6:0], 1'b0};
          end else begin
            miso_d  = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end else begin
          miso_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= M_DROP;
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      act_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 24'd0;
      dato_q    <= 8'd0;
      txbuf_q   <= 8'd0;
      tx_sr_q   <= 8'd0;
      miso_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      act_q     <= act_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dato_q    <= dato_d;
      txbuf_q   <= txbuf_d;
      tx_sr_q   <= tx_sr_d;
      miso_q    <= miso_d;
      rd_pend_q <= rd_pend_d;
      lat_q     <= lat_d;
    end
  end

  assign pi       = {act_q, we_q, addr_q, dato_q, map};
  assign spi_miso = miso_q & ~spi_ss;

endmodule

`default_nettype wire
